// File: rtl/fbext_console_writer.sv
// fbext_console_writer
// Character-stream front end for the HDMI text console. Bytes arrive over a
// valid/ready handshake, the cursor is tracked internally and every visible
// effect becomes a {attr, code} word written to the character RAM port.
// Because that port is write-only, a shadow copy of the screen is kept here
// so that scroll-up can read back the existing contents.

module fbext_console_writer #(
    parameter int         COLS           = 80,
    parameter int         ROWS           = 30,
    parameter logic [7:0] DEFAULT_ATTR   = 8'h0F,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ch_d,
    input  logic        ch_valid,
    output logic        ch_ready,
    input  logic [7:0]  attr_d,
    input  logic        attr_we,
    output logic [11:0] fb_a,
    output logic [15:0] fb_d,
    output logic        fb_we,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam int TOTAL = COLS * ROWS;

    // Address landmarks, all in the 12-bit address space of the RAM port.
    localparam logic [11:0] COLS_A     = 12'(COLS);
    localparam logic [11:0] LAST_A     = 12'(TOTAL - 1);
    localparam logic [11:0] LAST_ROW_A = 12'((ROWS - 1) * COLS);
    localparam logic [11:0] LAST_DST_A = 12'(TOTAL - 1 - COLS);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SCROLL  = 2'd1;
    localparam logic [1:0] ST_CLR_ROW = 2'd2;
    localparam logic [1:0] ST_CLR_ALL = 2'd3;

    localparam logic [1:0] RESET_STATE = CLEAR_ON_RESET ? ST_CLR_ALL : ST_IDLE;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [7:0]  attr;

    // Shared sweep counter for both clear flavours.
    logic [11:0] clr_addr;
    logic [11:0] clr_addr_n;

    // Scroll source pointer and the one-stage pipeline that carries the
    // destination address alongside the shadow read.
    logic [11:0] src_addr;
    logic [11:0] src_addr_n;
    logic        cp_valid;
    logic        cp_valid_n;
    logic [11:0] cp_dst;
    logic [11:0] cp_dst_n;
    logic        rd_en;
    logic [15:0] rd_data;

    logic [15:0] shadow [TOTAL];

    logic [6:0]  cur_x_n;
    logic [4:0]  cur_y_n;
    logic        we_n;
    logic [11:0] a_n;
    logic [15:0] d_n;
    logic        printable;
    logic [11:0] cur_addr;

    assign printable = (ch_d >= CH_SPACE) && (ch_d != CH_DEL);
    assign cur_addr  = 12'(cur_y) * COLS_A + 12'(cur_x);

    // Next-state, cursor and next RAM write for every state.
    always_comb begin
        state_n    = state;
        cur_x_n    = cur_x;
        cur_y_n    = cur_y;
        clr_addr_n = clr_addr;
        src_addr_n = src_addr;
        cp_valid_n = 1'b0;
        cp_dst_n   = cp_dst;
        rd_en      = 1'b0;
        we_n       = 1'b0;
        a_n        = fb_a;
        d_n        = fb_d;

        case (state)
            ST_IDLE: begin
                if (ch_valid) begin
                    if (printable) begin
                        we_n = 1'b1;
                        a_n  = cur_addr;
                        d_n  = {attr, ch_d};
                        if (cur_x < LAST_COL) begin
                            cur_x_n = cur_x + 7'd1;
                        end else begin
                            cur_x_n = 7'd0;
                            if (cur_y < LAST_ROW) begin
                                cur_y_n = cur_y + 5'd1;
                            end else begin
                                state_n    = ST_SCROLL;
                                src_addr_n = COLS_A;
                            end
                        end
                    end else if (ch_d == CH_CR) begin
                        cur_x_n = 7'd0;
                    end else if (ch_d == CH_LF) begin
                        cur_x_n = 7'd0;
                        if (cur_y < LAST_ROW) begin
                            cur_y_n = cur_y + 5'd1;
                        end else begin
                            state_n    = ST_SCROLL;
                            src_addr_n = COLS_A;
                        end
                    end else if (ch_d == CH_BS) begin
                        if (cur_x != 7'd0) begin
                            cur_x_n = cur_x - 7'd1;
                        end
                    end else if (ch_d == CH_FF) begin
                        state_n    = ST_CLR_ALL;
                        clr_addr_n = 12'd0;
                        cur_x_n    = 7'd0;
                        cur_y_n    = 5'd0;
                    end
                end
            end

            ST_SCROLL: begin
                if (src_addr <= LAST_A) begin
                    rd_en      = 1'b1;
                    cp_valid_n = 1'b1;
                    cp_dst_n   = src_addr - COLS_A;
                    src_addr_n = src_addr + 12'd1;
                end
                if (cp_valid) begin
                    we_n = 1'b1;
                    a_n  = cp_dst;
                    d_n  = rd_data;
                    if (cp_dst == LAST_DST_A) begin
                        state_n    = ST_CLR_ROW;
                        clr_addr_n = LAST_ROW_A;
                    end
                end
            end

            default: begin
                we_n = 1'b1;
                a_n  = clr_addr;
                d_n  = {attr, CH_SPACE};
                if (clr_addr == LAST_A) begin
                    state_n    = ST_IDLE;
                    clr_addr_n = 12'd0;
                end else begin
                    clr_addr_n = clr_addr + 12'd1;
                end
            end
        endcase
    end

    // Register state, cursor, handshake and the RAM write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            attr     <= DEFAULT_ATTR;
            clr_addr <= 12'd0;
            src_addr <= 12'd0;
            cp_valid <= 1'b0;
            cp_dst   <= 12'd0;
            cur_x    <= 7'd0;
            cur_y    <= 5'd0;
            fb_we    <= 1'b0;
            fb_a     <= 12'd0;
            fb_d     <= 16'd0;
            ch_ready <= !CLEAR_ON_RESET;
            busy     <= CLEAR_ON_RESET;
        end else begin
            state    <= state_n;
            clr_addr <= clr_addr_n;
            src_addr <= src_addr_n;
            cp_valid <= cp_valid_n;
            cp_dst   <= cp_dst_n;
            cur_x    <= cur_x_n;
            cur_y    <= cur_y_n;
            fb_we    <= we_n;
            fb_a     <= a_n;
            fb_d     <= d_n;
            ch_ready <= (state_n == ST_IDLE);
            busy     <= (state_n != ST_IDLE);
            if (attr_we) begin
                attr <= attr_d;
            end
        end
    end

    // Shadow screen: mirrors each registered RAM write one cycle later and
    // serves the scroll reads; reads only target addresses above the ones
    // being rewritten, so the delayed mirror never races a read.
    always_ff @(posedge clk) begin
        if (fb_we) begin
            shadow[fb_a] <= fb_d;
        end
        if (rd_en) begin
            rd_data <= shadow[src_addr];
        end
    end

endmodule
